// File: rtl/rr_arbiter16.sv
// Sixteen-way round-robin arbiter with registered one-hot grant and binary grant index.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD hold-limit counter and the timeout pulse.
module rr_arbiter16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid,
    output logic        timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic       win_found;
    logic [3:0] win_id;
    logic [3:0] scan_idx;
    logic       hold_expire;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter16: MAX_HOLD must be in 1..255");
    end

    // Rotating priority scan: the first requester at or after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        scan_idx  = ptr;
        for (int k = 0; k < 16; k++) begin
            scan_idx = ptr + 4'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign hold_expire = (hold_cnt == HOLD_LAST);
    assign timeout     = timeout_q;

    // A release that coincides with the limit is an ordinary release, so no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == GRANT) && req[gnt_id] && hold_expire;
            if (state == GRANT) begin
                hold_cnt <= hold_cnt + 8'd1;
            end else begin
                hold_cnt <= 8'd0;
            end
        end
    end
`else
    assign hold_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 4'd0;
            gnt       <= 16'h0000;
            gnt_id    <= 4'd0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state     <= GRANT;
                        gnt       <= 16'h0001 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    // gnt_id is left as-is on release; the owner moves to last priority.
                    if (!req[gnt_id] || hold_expire) begin
                        state     <= IDLE;
                        gnt       <= 16'h0000;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
